// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing defaults, frame-buffer geometry and pixel helpers
package vga_timing_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int FB_DEPTH     = H_ACTIVE_DEF * V_ACTIVE_DEF;
  localparam int ADDR_W       = $clog2(FB_DEPTH);

  // Active-high timing flags carried down the alignment pipeline.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } tim_t;

  function automatic logic [11:0] rgb332_expand(input logic [7:0] p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction
endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: h/v raster counters with raw active/sync/origin decode
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(HT),
  localparam int VW = $clog2(VT)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable_i,
  output tim_t raw_o
);
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic h_end, v_end;

  assign h_end = h_q == HW'(HT - 1);
  assign v_end = v_q == VW'(VT - 1);

  always_comb begin
    h_d = (!enable_i || h_end) ? '0 : h_q + 1'b1;
    v_d = !enable_i ? '0 : !h_end ? v_q : v_end ? '0 : v_q + 1'b1;
  end

  // A disabled counter parks at the origin, so its decode is masked to idle.
  always_comb begin
    raw_o = '0;
    if (enable_i) begin
      raw_o.de = h_q < HW'(H_ACTIVE) && v_q < VW'(V_ACTIVE);
      raw_o.hs = h_q >= HW'(H_ACTIVE + H_FP) && h_q < HW'(H_ACTIVE + H_FP + H_SYNC);
      raw_o.vs = v_q >= VW'(V_ACTIVE + V_FP) && v_q < VW'(V_ACTIVE + V_FP + V_SYNC);
      raw_o.fs = h_q == '0 && v_q == '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster scan-out with frame-memory address generation and RGB332 expansion
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              blank_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              de,
  output logic              frame_start
);
  tim_t raw, s1_q, s2_q;
  logic blank2_q;
  logic [ADDR_W-1:0] addr_q, addr_d, nxt_q, nxt_d;
  logic [11:0] rgb_q, rgb_d;
  logic hs_q, vs_q, de_q, fs_q;

  vga_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable_i (enable),
    .raw_o    (raw)
  );

  // nxt_q is the address the next active pixel will take; mem_addr only ever
  // advances to it on an active pixel, so it never runs past the last pixel.
  always_comb begin
    addr_d = (!enable || raw.fs) ? '0 : raw.de ? nxt_q : addr_q;
    nxt_d  = raw.fs ? ADDR_W'(1) : raw.de ? nxt_q + 1'b1 : nxt_q;
    rgb_d  = (s2_q.de && !blank2_q) ? rgb332_expand(mem_data) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      blank2_q <= 1'b0;
      addr_q   <= '0;
      nxt_q    <= '0;
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      blank2_q <= blank_in;
      addr_q   <= addr_d;
      nxt_q    <= nxt_d;
      rgb_q    <= rgb_d;
      hs_q     <= ~s2_q.hs;
      vs_q     <= ~s2_q.vs;
      de_q     <= s2_q.de;
      fs_q     <= s2_q.fs;
    end
  end

  assign mem_addr              = addr_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hs                = hs_q;
  assign vga_vs                = vs_q;
  assign de                    = de_q;
  assign frame_start           = fs_q;
endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have port clk  input  1  pixel clock (25 MHz), the only clock.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable  input  1  run scan; low holds timing idle.
REQ-008 SHALL have port blank_in  input  1  force black pixels (frame memory clear in progress); timing continues.
REQ-009 SHALL have port mem_addr  output  19  frame-memory read address, y*640+x.
REQ-010 SHALL have port mem_data  input  8  frame-memory pixel, RGB332, valid one clock after mem_addr.
REQ-011 SHALL have ports vga_r/vga_g/vga_b  output  4 each  pixel colour.
REQ-012 SHALL have ports vga_hs, vga_vs  output  1 each  active-low sync.
REQ-013 SHALL have ports de (active video) and frame_start (1-clock pulse)  output  1 each.

Function
REQ-014 SHALL count h 0..H_total-1 (800), wrapping to 0, and increment v (0..V_total-1 = 524) on each h wrap, v wrapping to 0.
REQ-015 SHALL mark counter-stage active when h<640 and v<480; hs active when 656<=h<752; vs active when 490<=v<492.
REQ-016 SHALL generate mem_addr incrementally (no multiplier): +1 per active pixel, hold during blanking, 0 when h=0,v=0.
REQ-017 SHALL register mem_addr in stage 1 together with de/hs/vs; delay de/hs/vs one more stage to align with mem_data (stage 2); register outputs in stage 3; total latency 3 clocks from counter to pins.
REQ-018 SHALL expand RGB332 as r={p[7:5],p[7]}, g={p[4:2],p[4]}, b={p[1:0],p[1:0]}.
REQ-019 SHALL drive r/g/b to 0 whenever aligned de=0 or blank_in=1 (blank_in sampled at stage 2).
REQ-020 SHALL pulse frame_start for one clock, aligned with the output pixel at h=0,v=0.
REQ-021 SHALL, while enable=0, hold h=v=0, mem_addr=0, de=0, vga_hs=vga_vs=1, rgb=0, frame_start=0; on enable rising, first output pixel (0,0) appears 3 clocks later with frame_start.
REQ-022 SHALL never emit mem_addr >= 307200; last active address is 307199.
REQ-023 SHALL, on enable dropping mid-frame, reset counters on the next clock; the pipeline drains as blank.

Reset
REQ-024 SHALL, on reset_n low, asynchronously clear h, v, mem_addr, all pipeline registers; outputs: vga_hs=1, vga_vs=1, de=0, rgb=0, frame_start=0, mem_addr=0.
REQ-025 SHALL, on reset_n release mid-frame, restart from (0,0) when enable=1.

Structure
REQ-026 SHALL place timing defaults, H_TOTAL/V_TOTAL, FB_DEPTH=307200 and address width 19 in shared package vga_timing_pkg.
REQ-027 SHALL implement h/v counters and raw sync/active decode in sub-module vga_timing_counter; vga_scanout holds address generator, alignment pipeline, colour expansion.

Verification
REQ-028 Reset: reset_n=0 with enable=1 -> hs=vs=1, de=0, rgb=0, mem_addr=0 immediately, without a clock edge.
REQ-029 Line timing: enable=1 for 2 lines -> de high exactly 640 clocks per line, hs low 96 clocks starting 656 clocks after de rise, period 800.
REQ-030 Frame: run one frame -> 480 de lines, vs low 2 lines starting at line 490, frame_start once per 420000 clocks, last mem_addr 307199, then 0.
REQ-031 Data alignment: memory model returns addr[7:0]; pixel (3,0) -> mem_data=0x03 -> r=0,g=0,b=0xF; pixel 255 with mem_data=0xFF -> r=g=b=0xF.
REQ-032 blank_in=1 for one line while memory returns 0xFF -> rgb=0 on that line, hs/vs/de unchanged.
REQ-033 enable dropped at h=100,v=50 then raised -> outputs blank within 3 clocks, restart with frame_start 3 clocks after rise, mem_addr restarts at 0.
